// File: rtl/sccb_responder.sv
// SCCB target with a 256x8 register file; decodes 3-phase writes and 2-phase reads.
// Define SCCB_ACK_EN to drive siod low in the ID (on match), SUB and WDATA ACK slots.
`timescale 1ns/1ps
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID     = 8'h42,
  parameter int         FILTER_LEN    = 3,
  parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_drive_low,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic [7:0] sub_ptr
);

  localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);
`ifdef SCCB_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_NA, S_IGNORE
  } state_t;

  logic [1:0] r_sioc_sync, r_siod_sync;
  logic       r_sioc_f, r_siod_f, r_sioc_fd, r_siod_fd;
  logic [3:0] r_sioc_cnt, r_siod_cnt;

  state_t     r_state;
  logic [3:0] r_bitcnt;
  logic [6:0] r_shift;
  logic       r_read;
  logic [7:0] r_sub_ptr, r_rdbyte, r_wr_addr, r_wr_data;
  logic       r_drive, r_busy, r_wr_valid;
  logic [7:0] r_regs [256];

  logic       w_sioc_rise, w_sioc_fall, w_start, w_stop;
  logic [7:0] w_byte;

  // Filtered levels only move after FILTER_LEN consecutive samples disagree with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sioc_sync <= 2'b11;
      r_siod_sync <= 2'b11;
      r_sioc_f    <= 1'b1;
      r_siod_f    <= 1'b1;
      r_sioc_fd   <= 1'b1;
      r_siod_fd   <= 1'b1;
      r_sioc_cnt  <= '0;
      r_siod_cnt  <= '0;
    end else begin
      r_sioc_sync <= {r_sioc_sync[0], sioc};
      r_siod_sync <= {r_siod_sync[0], siod_in};
      r_sioc_fd   <= r_sioc_f;
      r_siod_fd   <= r_siod_f;
      if (r_sioc_sync[1] == r_sioc_f) begin
        r_sioc_cnt <= '0;
      end else if (r_sioc_cnt == FLT_MAX) begin
        r_sioc_f   <= r_sioc_sync[1];
        r_sioc_cnt <= '0;
      end else begin
        r_sioc_cnt <= r_sioc_cnt + 4'd1;
      end
      if (r_siod_sync[1] == r_siod_f) begin
        r_siod_cnt <= '0;
      end else if (r_siod_cnt == FLT_MAX) begin
        r_siod_f   <= r_siod_sync[1];
        r_siod_cnt <= '0;
      end else begin
        r_siod_cnt <= r_siod_cnt + 4'd1;
      end
    end
  end

  assign w_sioc_rise = r_sioc_f & ~r_sioc_fd;
  assign w_sioc_fall = ~r_sioc_f & r_sioc_fd;
  assign w_start     = r_sioc_f & r_sioc_fd & r_siod_fd & ~r_siod_f;
  assign w_stop      = r_sioc_f & r_sioc_fd & ~r_siod_fd & r_siod_f;
  assign w_byte      = {r_shift, r_siod_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_read     <= 1'b0;
      r_sub_ptr  <= '0;
      r_rdbyte   <= '0;
      r_drive    <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_bitcnt <= '0;
        r_drive  <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ID;
        r_bitcnt <= '0;
        r_drive  <= 1'b0;
        r_busy   <= 1'b1;
      end else if (w_sioc_rise) begin
        case (r_state)
          S_ID, S_SUB, S_WDATA, S_RDATA: begin
            r_shift <= w_byte[6:0];
            if (r_bitcnt == 4'd7) begin
              r_bitcnt <= 4'd8;
              case (r_state)
                S_ID: begin
                  if (w_byte == DEVICE_ID) begin
                    r_state <= S_ID_ACK;
                    r_read  <= 1'b0;
                  end else if (w_byte == (DEVICE_ID | 8'h01)) begin
                    r_state <= S_ID_ACK;
                    r_read  <= 1'b1;
                  end else begin
                    r_state <= S_IGNORE;
                  end
                end
                S_SUB: begin
                  r_sub_ptr <= w_byte;
                  r_state   <= S_SUB_ACK;
                end
                S_WDATA: begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_sub_ptr;
                  r_wr_data  <= w_byte;
                  r_state    <= S_WDATA_ACK;
                end
                default: r_state <= S_RD_NA;
              endcase
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          S_ID_ACK: begin
            r_bitcnt <= '0;
            if (r_read) begin
              r_state  <= S_RDATA;
              r_rdbyte <= r_regs[r_sub_ptr];
            end else begin
              r_state <= S_SUB;
            end
          end
          S_SUB_ACK: begin
            r_bitcnt <= '0;
            r_state  <= S_WDATA;
          end
          S_WDATA_ACK, S_RD_NA: begin
            r_bitcnt <= '0;
            r_state  <= S_IGNORE;
          end
          default: ;
        endcase
      end else if (w_sioc_fall) begin
        // siod only changes while sioc is low, so our own driving never forms START/STOP.
        case (r_state)
          S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: r_drive <= ACK_DRIVE;
          S_RDATA: begin
            r_drive  <= ~r_rdbyte[7];
            r_rdbyte <= {r_rdbyte[6:0], 1'b0};
          end
          default: r_drive <= 1'b0;
        endcase
      end
    end
  end

  // Written a cycle after wr_valid rises so a same-address host read still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) r_regs[i] <= REG_RESET_VAL;
    end else if (r_wr_valid) begin
      r_regs[r_wr_addr] <= r_wr_data;
    end
  end

  assign host_rdata     = r_regs[host_addr];
  assign siod_drive_low = r_drive;
  assign busy           = r_busy;
  assign wr_valid       = r_wr_valid;
  assign wr_addr        = r_wr_addr;
  assign wr_data        = r_wr_data;
  assign sub_ptr        = r_sub_ptr;

endmodule

// File: tb/tb_sccb_responder.sv
// Randomized bench for sccb_responder: an SCCB initiator model drives the bus and a
// transaction-level register model predicts ACKs, read data and write pulses.
`timescale 1ns/1ps
module tb_sccb_responder;

  localparam int Q = 100;
`ifdef SCCB_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busSioc = 1'b1;
  logic       busSda = 1'b1;
  logic       glitch = 1'b0;
  logic       glitchEn = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic       siocPin, siodPad;
  logic       siod_drive_low, busy, wr_valid;
  logic [7:0] wr_addr, wr_data, host_rdata, sub_ptr;

  int checks = 0;
  int failures = 0;

  logic [7:0] modelRegs [256];
  logic [7:0] modelSubPtr = 8'h00;
  int         expPulses = 0;

  int         pulseCnt = 0;
  int         driveCycles = 0;
  logic [7:0] lastAddr = 8'h00, lastData = 8'h00, hostOld = 8'h00, hostNew = 8'h00;
  logic       pendNew = 1'b0;

  assign siocPin = busSioc ^ glitch;
  assign siodPad = busSda & ~siod_drive_low;

  sccb_responder dut (
    .clk(clk), .rst_n(rst_n), .sioc(siocPin), .siod_in(siodPad),
    .siod_drive_low(siod_drive_low), .busy(busy), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .host_addr(host_addr),
    .host_rdata(host_rdata), .sub_ptr(sub_ptr)
  );

  always #5 clk = ~clk;

  // Short sioc glitches, each far narrower than one clk period.
  initial begin
    forever begin
      #($urandom_range(20, 60));
      if (glitchEn) begin
        glitch = 1'b1;
        #2;
        glitch = 1'b0;
      end
    end
  end

  // Passive monitor: counts write pulses and captures host_rdata around them.
  always @(negedge clk) begin
    if (wr_valid) begin
      pulseCnt = pulseCnt + 1;
      lastAddr = wr_addr;
      lastData = wr_data;
      hostOld  = host_rdata;
      pendNew  = 1'b1;
    end else if (pendNew) begin
      hostNew = host_rdata;
      pendNew = 1'b0;
    end
    if (siod_drive_low) driveCycles = driveCycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic busStart();
    busSda = 1'b1;  #Q;
    busSioc = 1'b1; #Q;
    busSda = 1'b0;  #Q;
    busSioc = 1'b0; #Q;
  endtask

  task automatic busStop();
    busSda = 1'b0;  #Q;
    busSioc = 1'b1; #Q;
    busSda = 1'b1;  #(2 * Q);
  endtask

  task automatic bitCycle(input logic b, output logic sampled, output logic drv);
    busSda = b;     #Q;
    busSioc = 1'b1; #Q;
    sampled = siodPad;
    drv = siod_drive_low;
    #Q;
    busSioc = 1'b0; #Q;
  endtask

  task automatic sendByte(input logic [7:0] v, output logic ack);
    logic s, d;
    for (int i = 7; i >= 0; i--) bitCycle(v[i], s, d);
    bitCycle(1'b1, ack, d);
  endtask

  task automatic recvByte(output logic [7:0] v, output logic naDrive);
    logic s, d;
    for (int i = 7; i >= 0; i--) begin
      bitCycle(1'b1, s, d);
      v[i] = s;
    end
    bitCycle(1'b1, s, naDrive);
  endtask

  function automatic logic expAck(input bit acked);
    return (acked && ACK_EN) ? 1'b0 : 1'b1;
  endfunction

  // Full 3-phase write; the model only takes it when the ID is our write address.
  task automatic applyStimulus(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data);
    logic a0, a1, a2;
    logic [7:0] oldVal;
    int startDrive;
    bit match;
    match = (id == 8'h42);
    host_addr = sub;
    oldVal = modelRegs[sub];
    startDrive = driveCycles;
    busStart();
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    sendByte(id, a0);
    sendByte(sub, a1);
    sendByte(data, a2);
    busStop();
    if (match) begin
      modelRegs[sub] = data;
      modelSubPtr = sub;
      expPulses = expPulses + 1;
    end
    checkOutput("ack_id", 32'(a0), 32'(expAck(match)));
    checkOutput("ack_sub", 32'(a1), 32'(expAck(match)));
    checkOutput("ack_data", 32'(a2), 32'(expAck(match)));
    checkOutput("wr_count", 32'(pulseCnt), 32'(expPulses));
    if (match) begin
      checkOutput("wr_addr", 32'(lastAddr), 32'(sub));
      checkOutput("wr_data", 32'(lastData), 32'(data));
      checkOutput("host_old_at_pulse", 32'(hostOld), 32'(oldVal));
      checkOutput("host_new_after", 32'(hostNew), 32'(data));
    end else begin
      checkOutput("no_drive_ignored", 32'(driveCycles), 32'(startDrive));
    end
    checkOutput("host_rdata", 32'(host_rdata), 32'(modelRegs[sub]));
    checkOutput("sub_ptr", 32'(sub_ptr), 32'(modelSubPtr));
    checkOutput("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic subOnly(input logic [7:0] sub, input bit doStop);
    logic a0, a1;
    busStart();
    sendByte(8'h42, a0);
    sendByte(sub, a1);
    if (doStop) busStop();
    modelSubPtr = sub;
    checkOutput("ack2_id", 32'(a0), 32'(expAck(1'b1)));
    checkOutput("ack2_sub", 32'(a1), 32'(expAck(1'b1)));
    checkOutput("sub_ptr_2phase", 32'(sub_ptr), 32'(modelSubPtr));
    checkOutput("wr_count_2phase", 32'(pulseCnt), 32'(expPulses));
  endtask

  task automatic readTxn();
    logic a0, naDrive;
    logic [7:0] v;
    busStart();
    checkOutput("busy_read", 32'(busy), 32'd1);
    sendByte(8'h43, a0);
    recvByte(v, naDrive);
    busStop();
    checkOutput("ack_rid", 32'(a0), 32'(expAck(1'b1)));
    checkOutput("rd_byte", 32'(v), 32'(modelRegs[modelSubPtr]));
    checkOutput("na_released", 32'(naDrive), 32'd0);
    checkOutput("wr_count_read", 32'(pulseCnt), 32'(expPulses));
    checkOutput("drive_after_read", 32'(siod_drive_low), 32'd0);
  endtask

  initial begin
    logic a0, a1;
    logic [7:0] id;
    for (int i = 0; i < 256; i++) modelRegs[i] = 8'h00;
    #(3 * Q);
    checkOutput("rst_drive", 32'(siod_drive_low), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sub_ptr", 32'(sub_ptr), 32'd0);
    rst_n = 1'b1;
    #(4 * Q);

    applyStimulus(8'h42, 8'h12, 8'h80);

    applyStimulus(8'h42, 8'h3A, 8'h04);
    subOnly(8'h3A, 1'b1);
    readTxn();

    applyStimulus(8'h60, 8'h3A, 8'h55);

    glitchEn = 1'b1;
    applyStimulus(8'h42, 8'h01, 8'hFF);
    glitchEn = 1'b0;

    applyStimulus(8'h42, 8'h20, 8'hAA);
    busStart();
    sendByte(8'h42, a0);
    sendByte(8'h20, a1);
    checkOutput("sub_ptr_mid", 32'(sub_ptr), 32'h20);
    rst_n = 1'b0;
    host_addr = 8'h20;
    #30;
    checkOutput("mid_rst_drive", 32'(siod_drive_low), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("mid_rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("mid_rst_sub_ptr", 32'(sub_ptr), 32'd0);
    checkOutput("mid_rst_reg20", 32'(host_rdata), 32'd0);
    busSioc = 1'b1;
    busSda = 1'b1;
    for (int i = 0; i < 256; i++) modelRegs[i] = 8'h00;
    modelSubPtr = 8'h00;
    #(4 * Q);
    rst_n = 1'b1;
    #(4 * Q);
    applyStimulus(8'h42, 8'h20, 8'hAA);

    applyStimulus(8'h42, 8'h05, 8'h5C);
    applyStimulus(8'h42, 8'h06, 8'h00);
    subOnly(8'h05, 1'b0);
    readTxn();

    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 4))
        0, 1: applyStimulus(8'h42, 8'h30 + 8'($urandom_range(0, 7)), 8'($urandom));
        2: readTxn();
        3: subOnly(8'h30 + 8'($urandom_range(0, 7)), 1'b1);
        default: begin
          id = 8'($urandom);
          if (id[7:1] == 7'h21) id = id ^ 8'h80;
          applyStimulus(id, 8'h30 + 8'($urandom_range(0, 7)), 8'($urandom));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
